// File: rtl/spi_controller.sv
// Byte-oriented SPI host engine: shifts one byte MSB-first over x1/x2/x4 lanes
// while assembling one received byte; spi_clk runs at clk/2 with CPOL=0, CPHA=0.
module spi_controller (
    input  logic       clk,
    input  logic       reset,
    output logic       spi_clk,
    input  logic [3:0] spi_data_in,
    output logic [3:0] spi_data_out,
    input  logic [2:0] spi_mode_in,
    input  logic       spi_byte_tx_strobe,
    input  logic [7:0] spi_byte_tx,
    output logic [7:0] spi_byte_rx,
    output logic       spi_idle
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_e;
    typedef enum logic [1:0] {LANE_X1, LANE_X2, LANE_X4} lane_e;

    state_e     state_q;
    lane_e      lane_q;
    lane_e      lane_d;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] rx_d;
    logic [2:0] beats_q;
    logic       sclk_q;
    logic [3:0] dout_q;
    logic [7:0] byte_rx_q;
    logic       idle_q;

    function automatic lane_e decode_mode(input logic [2:0] m);
        case (m)
            3'd2:    return LANE_X2;
            3'd4:    return LANE_X4;
            default: return LANE_X1;
        endcase
    endfunction

    function automatic logic [3:0] lead_bits(input lane_e l, input logic [7:0] b);
        case (l)
            LANE_X1: return {3'b000, b[7]};
            LANE_X2: return {2'b00, b[7:6]};
            default: return b[7:4];
        endcase
    endfunction

    function automatic logic [7:0] shift_out(input lane_e l, input logic [7:0] b);
        case (l)
            LANE_X1: return {b[6:0], 1'b0};
            LANE_X2: return {b[5:0], 2'b00};
            default: return {b[3:0], 4'b0000};
        endcase
    endfunction

    // Beats remaining after the first one; reaching zero in HIGH ends the byte.
    function automatic logic [2:0] beats_after_first(input lane_e l);
        case (l)
            LANE_X1: return 3'd7;
            LANE_X2: return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    assign lane_d = decode_mode(spi_mode_in);

    always_comb begin
        rx_d = rx_q;
        case (lane_q)
            LANE_X1: rx_d = {rx_q[6:0], spi_data_in[1]};
            LANE_X2: rx_d = {rx_q[5:0], spi_data_in[1:0]};
            default: rx_d = {rx_q[3:0], spi_data_in};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lane_q    <= LANE_X1;
            tx_q      <= '0;
            rx_q      <= '0;
            beats_q   <= '0;
            sclk_q    <= 1'b0;
            dout_q    <= '0;
            byte_rx_q <= '0;
            idle_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (spi_byte_tx_strobe) begin
                        lane_q  <= lane_d;
                        dout_q  <= lead_bits(lane_d, spi_byte_tx);
                        tx_q    <= shift_out(lane_d, spi_byte_tx);
                        beats_q <= beats_after_first(lane_d);
                        rx_q    <= '0;
                        idle_q  <= 1'b0;
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    sclk_q  <= 1'b1;
                    state_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    rx_q   <= rx_d;
                    sclk_q <= 1'b0;
                    if (beats_q == 3'd0) begin
                        byte_rx_q <= rx_d;
                        idle_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        beats_q <= beats_q - 3'd1;
                        dout_q  <= lead_bits(lane_q, tx_q);
                        tx_q    <= shift_out(lane_q, tx_q);
                        state_q <= ST_LOW;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi_clk      = sclk_q;
    assign spi_data_out = dout_q;
    assign spi_byte_rx  = byte_rx_q;
    assign spi_idle     = idle_q;

endmodule

// File: tb/tb_spi_controller.sv
// Randomized self-checking bench for spi_controller against a per-byte
// arithmetic reference model (lane width, beat slices, assembled rx byte).
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_out;
    logic [2:0] spi_mode_in;
    logic       spi_byte_tx_strobe;
    logic [7:0] spi_byte_tx;
    logic [7:0] spi_byte_rx;
    logic       spi_idle;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [3:0]  din_plan [8];

    spi_controller dut (
        .clk                (clk),
        .reset              (reset),
        .spi_clk            (spi_clk),
        .spi_data_in        (spi_data_in),
        .spi_data_out       (spi_data_out),
        .spi_mode_in        (spi_mode_in),
        .spi_byte_tx_strobe (spi_byte_tx_strobe),
        .spi_byte_tx        (spi_byte_tx),
        .spi_byte_rx        (spi_byte_rx),
        .spi_idle           (spi_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lane_w(input logic [2:0] m);
        return (m == 3'd2) ? 2 : (m == 3'd4) ? 4 : 1;
    endfunction

    function automatic logic [3:0] exp_out(input logic [7:0] tx, input int w, input int k);
        int v;
        v = (int'(tx) >> (8 - w * (k + 1))) & ((1 << w) - 1);
        return 4'(v);
    endfunction

    // Caller guarantees DUT idle, time = edge+1. Leaves time = edge+1 with DUT idle.
    task automatic xfer(input logic [7:0] tx, input logic [2:0] mode, input logic busy);
        int w, nb, busy_at, idle_low, rx_exp, lane;
        w        = lane_w(mode);
        nb       = 8 / w;
        rx_exp   = 0;
        idle_low = 0;
        busy_at  = int'($urandom_range(0, 2 * nb - 1));
        spi_byte_tx        = tx;
        spi_mode_in        = mode;
        spi_byte_tx_strobe = 1'b1;
        @(posedge clk); #1;
        spi_byte_tx_strobe = 1'b0;
        spi_byte_tx        = 8'($urandom);
        if (busy) spi_mode_in = 3'($urandom);
        for (int k = 0; k < nb; k++) begin
            if (!spi_idle) idle_low++;
            check("clk_low", {31'b0, spi_clk}, 0);
            check("dout_low", {28'b0, spi_data_out}, {28'b0, exp_out(tx, w, k)});
            spi_data_in        = din_plan[k];
            spi_byte_tx_strobe = busy && (busy_at == 2 * k);
            @(posedge clk); #1;
            spi_byte_tx_strobe = 1'b0;
            if (!spi_idle) idle_low++;
            check("clk_high", {31'b0, spi_clk}, 1);
            check("dout_high", {28'b0, spi_data_out}, {28'b0, exp_out(tx, w, k)});
            lane   = (w == 1) ? ((int'(din_plan[k]) >> 1) & 1) : (int'(din_plan[k]) & ((1 << w) - 1));
            rx_exp = ((rx_exp << w) | lane) & 8'hFF;
            spi_byte_tx_strobe = busy && (busy_at == 2 * k + 1);
            @(posedge clk); #1;
            spi_byte_tx_strobe = 1'b0;
        end
        check("idle_end", {31'b0, spi_idle}, 1);
        check("idle_low_cycles", idle_low, 2 * nb);
        check("clk_end", {31'b0, spi_clk}, 0);
        check("rx_byte", {24'b0, spi_byte_rx}, rx_exp);
        check("dout_hold", {28'b0, spi_data_out}, {28'b0, exp_out(tx, w, nb - 1)});
    endtask

    task automatic fill_din(input logic [3:0] v);
        for (int i = 0; i < 8; i++) din_plan[i] = v;
    endtask

    initial begin
        logic [2:0] modes [8];
        logic [7:0] b;
        modes = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd5, 3'd6, 3'd7};
        reset              = 1'b1;
        spi_data_in        = 4'h0;
        spi_mode_in        = 3'd1;
        spi_byte_tx_strobe = 1'b0;
        spi_byte_tx        = 8'h00;
        #12;
        check("rst_idle", {31'b0, spi_idle}, 1);
        check("rst_dout", {28'b0, spi_data_out}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("quiet_idle", {31'b0, spi_idle}, 1);
            check("quiet_clk", {31'b0, spi_clk}, 0);
            check("quiet_rx", {24'b0, spi_byte_rx}, 0);
            @(posedge clk); #1;
        end

        fill_din(4'h0);        xfer(8'hA5, 3'd1, 1'b0);
        fill_din(4'h2);        xfer(8'h00, 3'd1, 1'b0);
        fill_din(4'h0); din_plan[7] = 4'h2;
        xfer(8'h01, 3'd1, 1'b0);
        din_plan[0] = 4'hA; din_plan[1] = 4'h5;
        xfer(8'h3C, 3'd4, 1'b0);
        fill_din(4'h0);        xfer(8'hE4, 3'd2, 1'b0);

        // Back-to-back stream with strobes during busy and mid-byte mode changes.
        b = 8'hA5;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 8; i++) din_plan[i] = 4'($urandom);
            xfer(b, modes[$urandom_range(0, 7)], 1'b1);
            b = b + 8'd1;
        end

        // Abort at beat 3 of an x1 byte.
        fill_din(4'hF);
        spi_mode_in = 3'd1; spi_byte_tx = 8'h5A; spi_byte_tx_strobe = 1'b1;
        @(posedge clk); #1;
        spi_byte_tx_strobe = 1'b0;
        spi_data_in = 4'hF;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_clk", {31'b0, spi_clk}, 0);
        check("abort_dout", {28'b0, spi_data_out}, 0);
        check("abort_rx", {24'b0, spi_byte_rx}, 0);
        check("abort_idle", {31'b0, spi_idle}, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_abort_idle", {31'b0, spi_idle}, 1);
        for (int i = 0; i < 8; i++) din_plan[i] = 4'($urandom);
        xfer(8'hC3, 3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
